// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: registered loads with lane extraction and
// extension, single-cycle word stores, two-cycle read-modify-write for byte
// and halfword stores, and misalignment flagging in place of the access.
module load_store_unit #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_we,
    input  logic [31:0] mem_data_out
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned WIDXW = XLEN - 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    state_e            state_q;
    logic [WIDXW-1:0]  addr_q;
    logic [XLEN-1:0]   merged_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_rdata_q;
    logic              rsp_misaligned_q;

    logic              accept;
    logic              misaligned;
    logic [1:0]        byte_lane;
    logic              half_hi;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   merged_d;

    // Request decode: acceptance, alignment, lane selection and load extension
    always_comb begin
        accept     = (state_q == IDLE) & req_valid & ~rst;
        misaligned = 1'b0;
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase

        // Big-endian lane is 3-k, which for two bits is the bitwise inverse.
        byte_lane = BIG_ENDIAN ? ~req_addr[1:0] : req_addr[1:0];
        half_hi   = BIG_ENDIAN ? ~req_addr[1] : req_addr[1];

        byte_sel = 8'h00;
        case (byte_lane)
            2'd0:    byte_sel = mem_data_out[7:0];
            2'd1:    byte_sel = mem_data_out[15:8];
            2'd2:    byte_sel = mem_data_out[23:16];
            default: byte_sel = mem_data_out[31:24];
        endcase
        half_sel = half_hi ? mem_data_out[31:16] : mem_data_out[15:0];

        load_data = '0;
        case (req_size)
            SZ_BYTE: load_data = req_unsigned ? {24'h000000, byte_sel}
                                              : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = req_unsigned ? {16'h0000, half_sel}
                                              : {{16{half_sel[15]}}, half_sel};
            SZ_WORD: load_data = mem_data_out;
            default: load_data = '0;
        endcase
    end

    // Merge store data into the word read this cycle for the RMW write-back
    always_comb begin
        merged_d = mem_data_out;
        if (req_size == SZ_BYTE) begin
            case (byte_lane)
                2'd0:    merged_d = {mem_data_out[31:8], req_wdata[7:0]};
                2'd1:    merged_d = {mem_data_out[31:16], req_wdata[7:0], mem_data_out[7:0]};
                2'd2:    merged_d = {mem_data_out[31:24], req_wdata[7:0], mem_data_out[15:0]};
                default: merged_d = {req_wdata[7:0], mem_data_out[23:0]};
            endcase
        end else if (req_size == SZ_HALF) begin
            merged_d = half_hi ? {req_wdata[15:0], mem_data_out[15:0]}
                               : {mem_data_out[31:16], req_wdata[15:0]};
        end
    end

    // DataMemory port: request address in IDLE, latched address and merged word in WRITE
    always_comb begin
        req_ready   = (state_q == IDLE);
        mem_addr    = {2'b00, req_addr[31:2]};
        mem_data_in = req_wdata;
        mem_we      = 1'b0;
        if (state_q == WRITE) begin
            mem_addr    = {2'b00, addr_q};
            mem_data_in = merged_q;
            mem_we      = ~rst;
        end else if (accept && req_write && !misaligned && req_size == SZ_WORD) begin
            mem_we = 1'b1;
        end
    end

    // FSM, RMW latches and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            merged_q         <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            rsp_misaligned_q <= 1'b0;
        end else begin
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            rsp_misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            rsp_valid_q      <= 1'b1;
                            rsp_misaligned_q <= 1'b1;
                        end else if (!req_write) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= load_data;
                        end else if (req_size == SZ_WORD) begin
                            rsp_valid_q <= 1'b1;
                        end else begin
                            addr_q   <= req_addr[31:2];
                            merged_q <= merged_d;
                            state_q  <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_misaligned = rsp_misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word-wide DataMemory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic [31:0] mem_data_out;

    logic [31:0] mem [16];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        mis;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    load_store_unit #(.BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_we(mem_we), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural DataMemory: combinational read, write on the rising edge
    assign mem_data_out = mem[mem_addr[3:0]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr[3:0]] <= mem_data_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Response monitor: pop and compare, flag spurious or overdue responses
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            chk({exp_q[0].tag, "_missing"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                chk({e.tag, "_mis"}, 32'(rsp_misaligned), 32'(e.mis));
                chk({e.tag, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] rd, input logic mis, input int lat);
        exp_t e;
        e.tag = tag; e.rdata = rd; e.mis = mis; e.due = cyc + lat;
        exp_q.push_back(e);
    endtask

    // Wait for the negedge of the current cycle to sample combinational ports
    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[2] = 32'h80FF7F01;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        step(); step();
        rst = 1'b0;
        mid();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_mis", 32'(rsp_misaligned), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);

        // Back-to-back loads, one accept per cycle
        step();
        drive(1'b0, 2'b10, 1'b0, 32'h8, '0); expect_rsp("lw8", 32'h80FF7F01, 1'b0, 1); step();
        drive(1'b0, 2'b00, 1'b0, 32'h9, '0); expect_rsp("lb9", 32'hFFFFFFFF, 1'b0, 1); step();
        drive(1'b0, 2'b00, 1'b1, 32'h9, '0); expect_rsp("lbu9", 32'h000000FF, 1'b0, 1); step();
        drive(1'b0, 2'b01, 1'b0, 32'hA, '0); expect_rsp("lhA", 32'h00007F01, 1'b0, 1); step();
        drive(1'b0, 2'b01, 1'b0, 32'h8, '0); expect_rsp("lh8", 32'hFFFF80FF, 1'b0, 1); step();
        drive(1'b0, 2'b00, 1'b1, 32'h8, '0); expect_rsp("lbu8", 32'h00000080, 1'b0, 1); step();
        req_valid = 1'b0;
        step(); step();

        // Byte store read-modify-write
        mem[2] = 32'h11223344;
        drive(1'b1, 2'b00, 1'b0, 32'hB, 32'h000000AB); expect_rsp("sbB", 32'h0, 1'b0, 2);
        mid();
        chk("sb_n_ready", 32'(req_ready), 32'd1);
        chk("sb_n_we", 32'(mem_we), 32'd0);
        step();
        req_valid = 1'b0;
        mid();
        chk("sb_n1_ready", 32'(req_ready), 32'd0);
        chk("sb_n1_we", 32'(mem_we), 32'd1);
        chk("sb_n1_addr", mem_addr, 32'd2);
        step();
        mid();
        chk("sb_n2_word", mem[2], 32'h112233AB);
        chk("sb_n2_ready", 32'(req_ready), 32'd1);
        chk("sb_n2_we", 32'(mem_we), 32'd0);
        step();

        // Halfword store, then a load held across the busy cycle
        mem[1] = 32'h0;
        drive(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000BEEF); expect_rsp("sh6", 32'h0, 1'b0, 2);
        step();
        drive(1'b0, 2'b10, 1'b0, 32'h4, '0);
        mid();
        chk("sh_busy_ready", 32'(req_ready), 32'd0);
        step();
        expect_rsp("lw4_after_sh", 32'h0000BEEF, 1'b0, 1);
        step();
        req_valid = 1'b0;
        chk("sh_word1", mem[1], 32'h0000BEEF);
        step();

        // Misaligned / reserved accesses, back to back
        drive(1'b0, 2'b10, 1'b0, 32'h6, '0); expect_rsp("lw6_mis", 32'h0, 1'b1, 1);
        mid(); chk("mis_lw_we", 32'(mem_we), 32'd0); step();
        drive(1'b1, 2'b01, 1'b0, 32'h5, 32'h00001234); expect_rsp("sh5_mis", 32'h0, 1'b1, 1);
        mid(); chk("mis_sh_we", 32'(mem_we), 32'd0); step();
        drive(1'b1, 2'b11, 1'b0, 32'h4, 32'hCAFEF00D); expect_rsp("sz11_mis", 32'h0, 1'b1, 1);
        mid(); chk("mis_sz11_we", 32'(mem_we), 32'd0); step();
        req_valid = 1'b0;
        mid(); chk("mis_after_we", 32'(mem_we), 32'd0);
        chk("mis_word1", mem[1], 32'h0000BEEF);
        step();

        // Word store
        drive(1'b1, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF); expect_rsp("sw0", 32'h0, 1'b0, 1);
        mid();
        chk("sw_we", 32'(mem_we), 32'd1);
        chk("sw_addr", mem_addr, 32'd0);
        step();
        req_valid = 1'b0;
        mid();
        chk("sw_we_after", 32'(mem_we), 32'd0);
        chk("sw_word0", mem[0], 32'hDEADBEEF);
        step();

        // Reset during the WRITE cycle of a byte store drops the write
        mem[3] = 32'h55667788;
        drive(1'b1, 2'b00, 1'b0, 32'hC, 32'h00000099);
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        mid();
        chk("rstw_we", 32'(mem_we), 32'd0);
        step();
        rst = 1'b0;
        mid();
        chk("rstw_word3", mem[3], 32'h55667788);
        chk("rstw_valid", 32'(rsp_valid), 32'd0);
        chk("rstw_rdata", rsp_rdata, 32'd0);
        chk("rstw_mis", 32'(rsp_misaligned), 32'd0);
        chk("rstw_ready", 32'(req_ready), 32'd1);
        step(); step(); step();

        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
